// File: rtl/hamming_pkg.sv
// ============================================================================
// Module      : hamming_pkg
// Description : Shared types and codeword layout for the SECDED Hamming(16,11)
//               message path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hamming_pkg;

    typedef enum logic [1:0] {
        ST_OK        = 2'd0,
        ST_CORRECTED = 2'd1,
        ST_DOUBLE    = 2'd2
    } status_e;

    typedef enum logic [1:0] {
        S_LO  = 2'd0,
        S_HI  = 2'd1,
        S_OUT = 2'd2
    } state_e;

    // d1..d11 in ascending codeword position; position 0 is overall parity
    localparam int C_DATA_POS [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
    localparam int C_PAR_POS  [4]  = '{1, 2, 4, 8};

    function automatic logic [10:0] extract_data(input logic [15:0] i_cw);
        logic [10:0] w_d;
        w_d = '0;
        for (int k = 0; k < 11; k++) begin
            w_d[k] = i_cw[C_DATA_POS[k][3:0]];
        end
        return w_d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hamming_syndrome.sv
// ============================================================================
// Module      : hamming_syndrome
// Description : Combinational syndrome and overall-parity check of a 16-bit
//               SECDED Hamming(16,11) codeword.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hamming_syndrome
    import hamming_pkg::*;
(
    input  logic [15:0] i_codeword,
    output logic [3:0]  o_syndrome,
    output logic        o_parity
);

    // Syndrome bit k is the parity of every position whose index has bit k set
    always_comb begin
        o_syndrome = '0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 1; i < 16; i++) begin
                if ((i & C_PAR_POS[k]) != 0) begin
                    o_syndrome[k] = o_syndrome[k] ^ i_codeword[i];
                end
            end
        end
    end

    assign o_parity = ^i_codeword;

endmodule

`default_nettype wire

// File: rtl/hamming_decoder.sv
// ============================================================================
// Module      : hamming_decoder
// Description : Byte-stream SECDED Hamming(16,11) decoder with single-error
//               correction, double-error detection and optional saturating
//               error counters (enabled by HAMMING_DEC_STATS_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hamming_decoder
    import hamming_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_byte,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [10:0]      out_data,
    output logic [1:0]       out_status,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] corrected_cnt,
    output logic [CNT_W-1:0] double_cnt
);

    state_e      r_state;
    logic [7:0]  r_lo;
    logic [10:0] r_out_data;
    status_e     r_out_status;

    logic [15:0] w_cw;
    logic [15:0] w_fixed;
    logic [3:0]  w_syn;
    logic        w_par;
    status_e     w_dec_status;
    logic [10:0] w_dec_data;
    logic        w_in_hs;
    logic        w_out_hs;

    assign w_cw = {in_byte, r_lo};

    hamming_syndrome u_syndrome (
        .i_codeword (w_cw),
        .o_syndrome (w_syn),
        .o_parity   (w_par)
    );

    // Odd parity means a single error: at position S, or at bit 0 when S=0
    always_comb begin
        w_fixed      = w_cw;
        w_dec_status = ST_OK;
        if (w_par) begin
            w_dec_status = ST_CORRECTED;
            if (w_syn != 4'd0) begin
                w_fixed[w_syn] = ~w_cw[w_syn];
            end
        end else if (w_syn != 4'd0) begin
            w_dec_status = ST_DOUBLE;
        end
    end

    assign w_dec_data = extract_data(w_fixed);

    assign in_ready   = (r_state == S_LO) || (r_state == S_HI);
    assign out_valid  = (r_state == S_OUT);
    assign out_data   = r_out_data;
    assign out_status = r_out_status;
    assign w_in_hs    = in_valid && in_ready;
    assign w_out_hs   = out_valid && out_ready;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state      <= S_LO;
            r_lo         <= '0;
            r_out_data   <= '0;
            r_out_status <= ST_OK;
        end else begin
            case (r_state)
                S_LO: begin
                    if (w_in_hs) begin
                        r_lo    <= in_byte;
                        r_state <= S_HI;
                    end
                end
                S_HI: begin
                    if (w_in_hs) begin
                        r_out_data   <= w_dec_data;
                        r_out_status <= w_dec_status;
                        r_state      <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (w_out_hs) begin
                        r_state <= S_LO;
                    end
                end
                default: r_state <= S_LO;
            endcase
        end
    end

`ifdef HAMMING_DEC_STATS_EN
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_corr_cnt;
    logic [CNT_W-1:0] r_dbl_cnt;

    always_ff @(posedge Clk) begin
        if (!Reset || clr_cnt) begin
            r_corr_cnt <= '0;
            r_dbl_cnt  <= '0;
        end else if (w_out_hs) begin
            if ((r_out_status == ST_CORRECTED) && (r_corr_cnt != '1)) begin
                r_corr_cnt <= r_corr_cnt + c_CNT_ONE;
            end
            if ((r_out_status == ST_DOUBLE) && (r_dbl_cnt != '1)) begin
                r_dbl_cnt <= r_dbl_cnt + c_CNT_ONE;
            end
        end
    end

    assign corrected_cnt = r_corr_cnt;
    assign double_cnt    = r_dbl_cnt;
`else
    logic w_unused_clr;
    assign w_unused_clr  = clr_cnt;
    assign corrected_cnt = '0;
    assign double_cnt    = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hamming_decoder.sv
// ============================================================================
// Module      : tb_hamming_decoder
// Description : Self-checking bench for hamming_decoder: directed cases plus
//               randomized byte traffic against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hamming_decoder;

    localparam int CNT_W = 2;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic             Clk = 1'b0;
    logic             Reset = 1'b0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_byte = 8'h00;
    logic             out_ready = 1'b0;
    logic             clr_cnt = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic [10:0]      out_data;
    logic [1:0]       out_status;
    logic [CNT_W-1:0] corrected_cnt;
    logic [CNT_W-1:0] double_cnt;

    hamming_decoder #(.CNT_W(CNT_W)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_byte       (in_byte),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_status    (out_status),
        .clr_cnt       (clr_cnt),
        .corrected_cnt (corrected_cnt),
        .double_cnt    (double_cnt)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference decode: returns {data[10:0], status[1:0]}
    function automatic logic [12:0] ref_decode(input logic [15:0] cw);
        int          pos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
        int          s = 0;
        int          p = 0;
        logic [15:0] c = cw;
        logic [1:0]  st;
        logic [10:0] d;
        for (int i = 0; i < 16; i++) begin
            if (cw[i]) begin
                s = s ^ i;
                p = p ^ 1;
            end
        end
        if (s == 0 && p == 0)      st = 2'd0;
        else if (p == 1) begin
            st = 2'd1;
            if (s != 0) c[s] = ~c[s];
        end else                   st = 2'd2;
        for (int k = 0; k < 11; k++) d[k] = c[pos[k]];
        return {d, st};
    endfunction

    function automatic logic [15:0] encode(input logic [10:0] d);
        int          pos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
        int          pp  [4]  = '{1, 2, 4, 8};
        logic [15:0] c = '0;
        for (int k = 0; k < 11; k++) c[pos[k]] = d[k];
        for (int j = 0; j < 4; j++) begin
            for (int i = 1; i < 16; i++) begin
                if ((i & pp[j]) != 0) c[pp[j]] = c[pp[j]] ^ c[i];
            end
        end
        c[0] = ^c[15:1];
        return c;
    endfunction

    function automatic int exp_cnt(input int v);
`ifdef HAMMING_DEC_STATS_EN
        return v;
`else
        return 0;
`endif
    endfunction

    // Transaction-level model: the decoder either holds one word or takes bytes
    bit          m_ov = 1'b0;
    logic [10:0] m_data = '0;
    logic [1:0]  m_st = '0;
    bit          m_half = 1'b0;
    logic [7:0]  m_lo = '0;
    int          m_corr = 0;
    int          m_dbl = 0;

    always @(posedge Clk) begin
        bit          rdy;
        logic [12:0] r;
        if (!Reset) begin
            m_ov = 0; m_data = '0; m_st = '0; m_half = 0; m_corr = 0; m_dbl = 0;
        end else begin
            rdy = !m_ov;
            if (m_ov && out_ready) begin
                if (m_st == 2'd1 && m_corr < SAT) m_corr++;
                if (m_st == 2'd2 && m_dbl < SAT) m_dbl++;
                m_ov = 0;
            end
            if (clr_cnt) begin
                m_corr = 0;
                m_dbl  = 0;
            end
            if (in_valid && rdy) begin
                if (!m_half) begin
                    m_lo   = in_byte;
                    m_half = 1;
                end else begin
                    r      = ref_decode({in_byte, m_lo});
                    m_data = r[12:2];
                    m_st   = r[1:0];
                    m_half = 0;
                    m_ov   = 1;
                end
            end
        end
    end

    always @(negedge Clk) begin
        if (mon_en) begin
            chk("mon_out_valid", out_valid, m_ov);
            chk("mon_in_ready", in_ready, !m_ov);
            chk("mon_out_data", out_data, m_data);
            chk("mon_out_status", out_status, m_st);
            chk("mon_corrected_cnt", corrected_cnt, exp_cnt(m_corr));
            chk("mon_double_cnt", double_cnt, exp_cnt(m_dbl));
        end
    end

    task automatic put_byte(input logic [7:0] b, input string nm);
        @(negedge Clk);
        in_valid = 1'b1;
        in_byte  = b;
        for (int t = 0; t < 20 && !in_ready; t++) @(negedge Clk);
        if (!in_ready) chk({nm, "_in_ready_timeout"}, 0, 1);
    endtask

    task automatic send_word(input logic [15:0] cw, input bit ordy,
                             input logic [10:0] ed, input logic [1:0] es, input string nm);
        out_ready = ordy;
        put_byte(cw[7:0], nm);
        put_byte(cw[15:8], nm);
        @(negedge Clk);
        in_valid = 1'b0;
        chk({nm, "_valid"}, out_valid, 1);
        chk({nm, "_data"}, out_data, ed);
        chk({nm, "_status"}, out_status, es);
    endtask

    function automatic logic [15:0] gen_word();
        logic [15:0] c;
        int          nflip;
        c     = encode(11'($urandom));
        nflip = $urandom_range(0, 2);
        for (int i = 0; i < nflip; i++) c[$urandom_range(0, 15)] ^= 1'b1;
        return c;
    endfunction

    initial begin
        logic [15:0] cur;
        bit          half;
        bit          consumed;

        repeat (3) @(negedge Clk);
        mon_en = 1'b1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_status", out_status, 0);
        chk("rst_in_ready", in_ready, 1);
        Reset = 1'b1;

        chk("model_0028", ref_decode(16'h0028), {11'h003, 2'd2});
        chk("model_enc_7ff", encode(11'h7FF), 16'hFFFF);

        send_word(16'h0000, 1, 11'h000, 2'd0, "zero");
        send_word(16'hFFFF, 1, 11'h7FF, 2'd0, "ones");
        send_word(16'hFFFE, 1, 11'h7FF, 2'd1, "bit0_err");
        send_word(16'h0020, 1, 11'h000, 2'd1, "bit5_err");
        send_word(16'h0028, 1, 11'h003, 2'd2, "double");
        @(negedge Clk);
        chk("double_cnt_one", double_cnt, exp_cnt(1));

        // Backpressure: word held while bytes are offered but refused
        send_word(16'h0020, 0, 11'h000, 2'd1, "bp");
        in_valid = 1'b1;
        in_byte  = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_data", out_data, 11'h000);
            chk("bp_hold_status", out_status, 2'd1);
            chk("bp_hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        send_word(16'hFFFF, 1, 11'h7FF, 2'd0, "bp_next");

        // Reset after a lone low byte
        put_byte(8'h20, "rst_mid");
        @(negedge Clk);
        in_valid = 1'b0;
        Reset    = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_corr", corrected_cnt, 0);
        chk("rst_mid_dbl", double_cnt, 0);
        send_word(16'hFFFF, 1, 11'h7FF, 2'd0, "post_rst");

        for (int i = 0; i < 5; i++) begin
            send_word(16'h0020, 1, 11'h000, 2'd1, "sat");
            @(negedge Clk);
            chk("sat_corr_cnt", corrected_cnt, exp_cnt((i + 1 < SAT) ? i + 1 : SAT));
        end
        send_word(16'h0020, 0, 11'h000, 2'd1, "clr");
        out_ready = 1'b1;
        clr_cnt   = 1'b1;
        @(negedge Clk);
        clr_cnt = 1'b0;
        chk("clr_corr_cnt", corrected_cnt, 0);

        // Randomized traffic, including occasional resets and counter clears
        cur      = gen_word();
        half     = 1'b0;
        consumed = 1'b0;
        repeat (1500) begin
            @(negedge Clk);
            if (consumed) begin
                if (!half) half = 1'b1;
                else begin
                    half = 1'b0;
                    cur  = gen_word();
                end
            end
            Reset     = ($urandom_range(0, 99) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_byte   = half ? cur[15:8] : cur[7:0];
            out_ready = ($urandom_range(0, 2) != 0);
            clr_cnt   = ($urandom_range(0, 39) == 0);
            consumed  = Reset && in_valid && in_ready;
        end

        @(negedge Clk);
        Reset    = 1'b1;
        in_valid = 1'b0;
        clr_cnt  = 1'b0;
        @(negedge Clk);
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
